// File: rtl/gato_pkg.sv
// Shared definitions for the Gato (tic-tac-toe) board logic.
// Holds the cell symbol codes, the default cell width and the turn encoding.
package gato_pkg;

  localparam int unsigned ANCHO_CELDA_DEF = 2;

  localparam int unsigned CELDA_VACIA = 0;
  localparam int unsigned CELDA_X     = 1;
  localparam int unsigned CELDA_O     = 2;

  typedef enum logic {
    TURNO_X = 1'b0,
    TURNO_O = 1'b1
  } turno_e;

  // Symbol code the player on turn must write.
  function automatic int unsigned simbolo_turno(input turno_e t);
    return (t == TURNO_O) ? CELDA_O : CELDA_X;
  endfunction

endpackage

// File: rtl/registro_tablero_if.sv
// Move write port of the board register.
//   wr_valid : move request, sampled every cycle
//   wr_dir   : target cell index
//   wr_dato  : symbol code (1 = X, 2 = O)
//   wr_ack   : one-cycle pulse, request accepted
//   wr_err   : one-cycle pulse, request rejected
// master = move source, slave = board register.
interface registro_tablero_if
  import gato_pkg::*;
#(
  parameter int unsigned N_CELDAS    = 9,
  parameter int unsigned ANCHO_CELDA = ANCHO_CELDA_DEF
);
  localparam int unsigned ANCHO_DIR = $clog2(N_CELDAS);

  logic                   wr_valid;
  logic [ANCHO_DIR-1:0]   wr_dir;
  logic [ANCHO_CELDA-1:0] wr_dato;
  logic                   wr_ack;
  logic                   wr_err;

  modport master (output wr_valid, wr_dir, wr_dato, input  wr_ack, wr_err);
  modport slave  (input  wr_valid, wr_dir, wr_dato, output wr_ack, wr_err);

endinterface

// File: rtl/pila_movimientos.sv
// LIFO of accepted move addresses, used to undo moves.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the stack)
//   vaciar_i     : synchronous clear (empties the stack)
//   push_i       : store dato_i on top (ignored when full)
//   pop_i        : drop the top entry (ignored when empty)
//   dato_i       : value to push
//   cima_c_o     : current top entry (combinational read of the storage)
//   vacia_o      : registered empty flag
module pila_movimientos #(
  parameter int unsigned PROFUNDIDAD = 9,
  parameter int unsigned ANCHO       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vaciar_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [ANCHO-1:0] dato_i,
  output logic [ANCHO-1:0] cima_c_o,
  output logic             vacia_o
);

  localparam int unsigned ANCHO_PTR = $clog2(PROFUNDIDAD + 1);

  logic [ANCHO-1:0]     mem_q [PROFUNDIDAD];
  logic [ANCHO_PTR-1:0] ptr_q, ptr_d;
  logic                 vacia_q;
  logic                 llena;

  assign llena = (ptr_q == ANCHO_PTR'(PROFUNDIDAD));

  // Pointer update: clear wins over pop, pop over push.
  always_comb begin
    ptr_d = ptr_q;
    if (vaciar_i) begin
      ptr_d = '0;
    end else if (pop_i && !vacia_q) begin
      ptr_d = ptr_q - ANCHO_PTR'(1);
    end else if (push_i && !llena) begin
      ptr_d = ptr_q + ANCHO_PTR'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      vacia_q <= 1'b1;
    end else begin
      ptr_q   <= ptr_d;
      vacia_q <= (ptr_d == '0);
    end
  end

  // Storage has no reset; only entries below the pointer are ever read.
  always_ff @(posedge clk) begin
    if (!reset && !vaciar_i && !pop_i && push_i && !llena) begin
      for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
        if (ANCHO_PTR'(i) == ptr_q) mem_q[i] <= dato_i;
      end
    end
  end

  // Top entry lives at index ptr_q-1.
  always_comb begin
    cima_c_o = '0;
    for (int unsigned i = 0; i < PROFUNDIDAD; i++) begin
      if (ANCHO_PTR'(i + 1) == ptr_q) cima_c_o = mem_q[i];
    end
  end

  assign vacia_o = vacia_q;

endmodule

// File: rtl/registro_tablero.sv
// Board-state register for the Gato game.
// Holds N_CELDAS cells of ANCHO_CELDA bits, accepts one move per cycle,
// rejects illegal moves and tracks turn, occupied count and full board.
// Optional undo support is built when REGISTRO_TABLERO_UNDO_EN is defined.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   limpiar    : synchronous clear of the game state
//   deshacer   : undo the last accepted move (undo build only)
//   wr         : move write port (slave side)
//   tablero    : registered board, cell i at [i*ANCHO_CELDA +: ANCHO_CELDA]
//   ocupadas   : number of non-empty cells
//   lleno      : ocupadas == N_CELDAS
//   turno      : 0 = X to move, 1 = O to move
module registro_tablero
  import gato_pkg::*;
#(
  parameter int unsigned N_CELDAS    = 9,
  parameter int unsigned ANCHO_CELDA = ANCHO_CELDA_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            limpiar,
  input  logic                            deshacer,
  registro_tablero_if.slave               wr,
  output logic [N_CELDAS*ANCHO_CELDA-1:0] tablero,
  output logic [$clog2(N_CELDAS+1)-1:0]   ocupadas,
  output logic                            lleno,
  output logic                            turno
);

  localparam int unsigned ANCHO_DIR  = $clog2(N_CELDAS);
  localparam int unsigned ANCHO_OCUP = $clog2(N_CELDAS + 1);
  localparam int unsigned ANCHO_TAB  = N_CELDAS * ANCHO_CELDA;

  logic [ANCHO_TAB-1:0]   tablero_q,  tablero_d;
  logic [ANCHO_OCUP-1:0]  ocupadas_q, ocupadas_d;
  logic                   turno_q,    turno_d;
  logic                   lleno_q;
  logic                   ack_q,      ack_d;
  logic                   err_q,      err_d;

  logic [ANCHO_CELDA-1:0] celda_sel;
  logic [ANCHO_CELDA-1:0] simbolo;
  logic                   dir_ok;
  logic                   legal;
  logic                   push;
  logic                   pop;

  // Read the addressed cell; out-of-range addresses read as empty but are
  // rejected by dir_ok.
  always_comb begin
    celda_sel = '0;
    for (int unsigned i = 0; i < N_CELDAS; i++) begin
      if (ANCHO_DIR'(i) == wr.wr_dir) celda_sel = tablero_q[i*ANCHO_CELDA +: ANCHO_CELDA];
    end
  end

  assign dir_ok  = (32'(wr.wr_dir) < N_CELDAS);
  assign simbolo = ANCHO_CELDA'(simbolo_turno(turno_e'(turno_q)));
  // The required symbol is never 0, so this also forbids erasing a cell.
  assign legal   = dir_ok && (celda_sel == '0) && (wr.wr_dato == simbolo) && !lleno_q;

`ifdef REGISTRO_TABLERO_UNDO_EN
  logic [ANCHO_DIR-1:0] cima;
  logic                 pila_vacia;

  pila_movimientos #(
    .PROFUNDIDAD (N_CELDAS),
    .ANCHO       (ANCHO_DIR)
  ) u_pila (
    .clk      (clk),
    .reset    (reset),
    .vaciar_i (limpiar),
    .push_i   (push),
    .pop_i    (pop),
    .dato_i   (wr.wr_dir),
    .cima_c_o (cima),
    .vacia_o  (pila_vacia)
  );
`else
  logic unused_deshacer;
  assign unused_deshacer = deshacer;
`endif

  // Next state: limpiar > deshacer > wr_valid.
  always_comb begin
    tablero_d  = tablero_q;
    ocupadas_d = ocupadas_q;
    turno_d    = turno_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (limpiar) begin
      tablero_d  = '0;
      ocupadas_d = '0;
      turno_d    = 1'b0;
    end
`ifdef REGISTRO_TABLERO_UNDO_EN
    else if (deshacer) begin
      if (!pila_vacia) begin
        pop = 1'b1;
        for (int unsigned i = 0; i < N_CELDAS; i++) begin
          if (ANCHO_DIR'(i) == cima) tablero_d[i*ANCHO_CELDA +: ANCHO_CELDA] = '0;
        end
        ocupadas_d = ocupadas_q - ANCHO_OCUP'(1);
        turno_d    = ~turno_q;
        ack_d      = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
`endif
    else if (wr.wr_valid) begin
      if (legal) begin
        push = 1'b1;
        for (int unsigned i = 0; i < N_CELDAS; i++) begin
          if (ANCHO_DIR'(i) == wr.wr_dir) tablero_d[i*ANCHO_CELDA +: ANCHO_CELDA] = wr.wr_dato;
        end
        // Cannot overflow: legal moves require a non-full board.
        ocupadas_d = ocupadas_q + ANCHO_OCUP'(1);
        turno_d    = ~turno_q;
        ack_d      = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tablero_q  <= '0;
      ocupadas_q <= '0;
      turno_q    <= 1'b0;
      lleno_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tablero_q  <= tablero_d;
      ocupadas_q <= ocupadas_d;
      turno_q    <= turno_d;
      lleno_q    <= (ocupadas_d == ANCHO_OCUP'(N_CELDAS));
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign tablero   = tablero_q;
  assign ocupadas  = ocupadas_q;
  assign lleno     = lleno_q;
  assign turno     = turno_q;
  assign wr.wr_ack = ack_q;
  assign wr.wr_err = err_q;

endmodule

// File: tb/tb_registro_tablero.sv
// Scoreboard bench for registro_tablero: the stimulus process applies one
// request per cycle, predicts the response from a game-level model and
// queues it; the monitor compares every cycle after the clock edge.
module tb_registro_tablero;

  localparam int N  = 9;
  localparam int AC = 2;
  localparam int AD = 4;
  localparam int AO = 4;

  logic          clk = 1'b0;
  logic          reset, limpiar, deshacer;
  logic [N*AC-1:0] tablero;
  logic [AO-1:0] ocupadas;
  logic          lleno, turno;

  registro_tablero_if #(.N_CELDAS(N), .ANCHO_CELDA(AC)) bus ();

  registro_tablero #(.N_CELDAS(N), .ANCHO_CELDA(AC)) dut (
    .clk      (clk),
    .reset    (reset),
    .limpiar  (limpiar),
    .deshacer (deshacer),
    .wr       (bus),
    .tablero  (tablero),
    .ocupadas (ocupadas),
    .lleno    (lleno),
    .turno    (turno)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ack;
    logic          err;
    logic [N*AC-1:0] tab;
    int            ocup;
    logic          lleno;
    logic          turno;
  } esp_t;

  esp_t cola[$];
  int   celdas[N];
  int   pila[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chequeo(input string nombre, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, req, $time);
    end
  endtask

  function automatic int contar();
    int c = 0;
    for (int i = 0; i < N; i++) if (celdas[i] != 0) c++;
    return c;
  endfunction

  // Apply one cycle of stimulus and queue the predicted post-edge state.
  task automatic paso(input bit r, input bit l, input bit d, input bit v,
                      input int dir, input int dato);
    esp_t e;
    int   cnt;
    reset        = r;
    limpiar      = l;
    deshacer     = d;
    bus.wr_valid = v;
    bus.wr_dir   = AD'(dir);
    bus.wr_dato  = AC'(dato);
    e.ack = 1'b0;
    e.err = 1'b0;
    if (r || l) begin
      for (int i = 0; i < N; i++) celdas[i] = 0;
      pila.delete();
    end
`ifdef REGISTRO_TABLERO_UNDO_EN
    else if (d) begin
      if (pila.size() > 0) begin
        celdas[pila.pop_back()] = 0;
        e.ack = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end
`endif
    else if (v) begin
      cnt = contar();
      // X moves when an even number of cells is filled, O otherwise.
      if (dir < N && celdas[dir] == 0 && dato == (cnt % 2) + 1 && cnt < N) begin
        celdas[dir] = dato;
        pila.push_back(dir);
        e.ack = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end
    cnt = contar();
    for (int i = 0; i < N; i++) e.tab[i*AC +: AC] = AC'(celdas[i]);
    e.ocup  = cnt;
    e.lleno = (cnt == N);
    e.turno = (cnt % 2 == 1);
    cola.push_back(e);
    @(negedge clk);
  endtask

  task automatic mover(input int dir, input int dato);
    paso(1'b0, 1'b0, 1'b0, 1'b1, dir, dato);
  endtask

  // Monitor: compare the DUT against the oldest prediction after each edge.
  initial begin
    esp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cola.size() > 0) begin
        e = cola.pop_front();
        chequeo("wr_ack",   bus.wr_ack, e.ack);
        chequeo("wr_err",   bus.wr_err, e.err);
        chequeo("tablero",  tablero,    e.tab);
        chequeo("ocupadas", ocupadas,   e.ocup);
        chequeo("lleno",    lleno,      e.lleno);
        chequeo("turno",    turno,      e.turno);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, dato, dir;
    for (int i = 0; i < N; i++) celdas[i] = 0;

    paso(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    paso(1'b1, 1'b0, 1'b0, 1'b1, 3, 1);
    paso(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Basic moves and rejections.
    mover(4, 1);
    mover(0, 2);
    mover(4, 1);
    mover(9, 1);
    mover(15, 1);
    mover(1, 2);
    mover(1, 0);

    // Move together with limpiar is dropped.
    paso(1'b0, 1'b1, 1'b0, 1'b1, 2, 1);
    paso(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Fill the board, then any further move fails.
    for (int i = 0; i < N; i++) mover(i, (i % 2) + 1);
    mover(3, 2);
    mover(3, 1);
    mover(12, 2);

    // Reset mid-game after five moves, then X plays first.
    paso(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) mover(8 - i, (i % 2) + 1);
    paso(1'b1, 1'b0, 1'b0, 1'b1, 0, 1);
    mover(6, 1);
    mover(5, 2);
    paso(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    // Undo requests (popping in undo build, ignored otherwise).
    mover(2, 1);
    mover(7, 2);
    paso(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    paso(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    paso(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    paso(1'b0, 1'b0, 1'b1, 1'b1, 4, 1);
    paso(1'b0, 1'b0, 1'b1, 1'b1, 5, 2);
    paso(1'b0, 1'b1, 1'b1, 1'b1, 0, 1);

    // Randomized traffic, biased toward legal moves.
    for (int k = 0; k < 3000; k++) begin
      cnt  = contar();
      dir  = ($urandom_range(4) == 0) ? int'($urandom_range(15)) : int'($urandom_range(N - 1));
      dato = ($urandom_range(3) != 0) ? (cnt % 2) + 1 : int'($urandom_range(3));
      paso($urandom_range(199) == 0, $urandom_range(59) == 0,
           $urandom_range(7) == 0, $urandom_range(3) != 0, dir, dato);
    end

    paso(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #2;
    chequeo("cola_vacia", cola.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
